// File: rtl/fft_peak_search.sv
// fft_peak_search: streaming spectral peak detector for one FFT output frame.
// Computes each bin's power as I^2+Q^2 and, at each frame end, reports the
// strongest bin inside the search range. Frames whose length disagrees with
// FFT_LEN are flagged with FRAME_ERR instead of a result.
//
// Ports
//   SYS_CLK        clock (300 MHz domain)
//   SYS_RSTN       asynchronous active-low reset
//   I_DATA_IN      signed real part of the current bin
//   Q_DATA_IN      signed imaginary part of the current bin
//   DATA_IN_VALID  bin present this cycle (no backpressure)
//   DATA_IN_LAST   last bin of the frame, qualified by DATA_IN_VALID
//   PEAK_BIN       index of the winning bin, held until the next result
//   PEAK_POWER     power of the winning bin, held until the next result
//   PEAK_VALID     one-cycle pulse per good frame
//   FRAME_ERR      one-cycle pulse per malformed frame
//   FRAME_CNT      count of good frames, wraps modulo 2^16
module fft_peak_search #(
    parameter int unsigned BIT_NUM     = 24,
    parameter int unsigned FFT_LEN     = 512,
    parameter bit          SKIP_DC     = 1'b1,
    parameter bit          SEARCH_HALF = 1'b1
) (
    input  logic                         SYS_CLK,
    input  logic                         SYS_RSTN,
    input  logic signed [BIT_NUM-1:0]    I_DATA_IN,
    input  logic signed [BIT_NUM-1:0]    Q_DATA_IN,
    input  logic                         DATA_IN_VALID,
    input  logic                         DATA_IN_LAST,
    output logic [$clog2(FFT_LEN)-1:0]   PEAK_BIN,
    output logic [2*BIT_NUM-1:0]         PEAK_POWER,
    output logic                         PEAK_VALID,
    output logic                         FRAME_ERR,
    output logic [15:0]                  FRAME_CNT
);

    localparam int unsigned IDX_W = $clog2(FFT_LEN);
    localparam int unsigned PW    = 2 * BIT_NUM;

    // ------------------------------------------------------------------
    // Bin counter and per-sample frame tags
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] idx;
    logic             idx_full_c;
    logic             end_c;
    logic             good_c;
    logic             in_range_c;

    // FFT_LEN is a power of two, so idx==FFT_LEN-1 is all-ones and
    // idx<FFT_LEN/2 is simply a clear MSB.
    always_comb begin
        idx_full_c = &idx;
        end_c      = DATA_IN_LAST | idx_full_c;
        good_c     = DATA_IN_LAST & idx_full_c;
        in_range_c = (!SKIP_DC || (idx != '0)) && (!SEARCH_HALF || !idx[IDX_W-1]);
    end

    // Bin counter: advances per accepted sample, restarts after any frame end
    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            idx <= '0;
        end else if (DATA_IN_VALID) begin
            idx <= end_c ? '0 : idx + IDX_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: register sample and its tags
    // ------------------------------------------------------------------
    logic                      s0_vld;
    logic signed [BIT_NUM-1:0] s0_i;
    logic signed [BIT_NUM-1:0] s0_q;
    logic [IDX_W-1:0]          s0_idx;
    logic                      s0_rng;
    logic                      s0_end;
    logic                      s0_good;

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            s0_vld  <= 1'b0;
            s0_i    <= '0;
            s0_q    <= '0;
            s0_idx  <= '0;
            s0_rng  <= 1'b0;
            s0_end  <= 1'b0;
            s0_good <= 1'b0;
        end else begin
            s0_vld  <= DATA_IN_VALID;
            s0_i    <= I_DATA_IN;
            s0_q    <= Q_DATA_IN;
            s0_idx  <= idx;
            s0_rng  <= DATA_IN_VALID & in_range_c;
            s0_end  <= DATA_IN_VALID & end_c;
            s0_good <= DATA_IN_VALID & good_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: squares, sign-extended to full output width
    // ------------------------------------------------------------------
    logic                 s1_vld;
    logic signed [PW-1:0] s1_pi;
    logic signed [PW-1:0] s1_pq;
    logic [IDX_W-1:0]     s1_idx;
    logic                 s1_rng;
    logic                 s1_end;
    logic                 s1_good;

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            s1_vld  <= 1'b0;
            s1_pi   <= '0;
            s1_pq   <= '0;
            s1_idx  <= '0;
            s1_rng  <= 1'b0;
            s1_end  <= 1'b0;
            s1_good <= 1'b0;
        end else begin
            s1_vld  <= s0_vld;
            s1_pi   <= PW'(s0_i) * PW'(s0_i);
            s1_pq   <= PW'(s0_q) * PW'(s0_q);
            s1_idx  <= s0_idx;
            s1_rng  <= s0_rng;
            s1_end  <= s0_end;
            s1_good <= s0_good;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: power sum; each square is non-negative so the unsigned
    // sum cannot exceed 2^(PW-1)
    // ------------------------------------------------------------------
    logic             s2_vld;
    logic [PW-1:0]    s2_pow;
    logic [IDX_W-1:0] s2_idx;
    logic             s2_rng;
    logic             s2_end;
    logic             s2_good;

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            s2_vld  <= 1'b0;
            s2_pow  <= '0;
            s2_idx  <= '0;
            s2_rng  <= 1'b0;
            s2_end  <= 1'b0;
            s2_good <= 1'b0;
        end else begin
            s2_vld  <= s1_vld;
            s2_pow  <= $unsigned(s1_pi) + $unsigned(s1_pq);
            s2_idx  <= s1_idx;
            s2_rng  <= s1_rng;
            s2_end  <= s1_end;
            s2_good <= s1_good;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: running maximum and frame result
    // ------------------------------------------------------------------
    logic             max_vld;
    logic [PW-1:0]    max_pow;
    logic [IDX_W-1:0] max_bin;
    logic             take_c;
    logic [PW-1:0]    best_pow_c;
    logic [IDX_W-1:0] best_bin_c;

    // First in-range bin loads unconditionally; strict compare keeps the
    // lowest index on ties. best_* includes the current bin so the
    // frame-end sample itself can win.
    always_comb begin
        take_c     = 1'b0;
        best_pow_c = max_pow;
        best_bin_c = max_bin;
        if (s2_vld && s2_rng && (!max_vld || (s2_pow > max_pow))) begin
            take_c = 1'b1;
        end
        if (take_c) begin
            best_pow_c = s2_pow;
            best_bin_c = s2_idx;
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RSTN) begin
        if (!SYS_RSTN) begin
            max_vld    <= 1'b0;
            max_pow    <= '0;
            max_bin    <= '0;
            PEAK_BIN   <= '0;
            PEAK_POWER <= '0;
            PEAK_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            FRAME_CNT  <= '0;
        end else begin
            PEAK_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            if (s2_vld && s2_end) begin
                // Search state is cleared at every frame end, good or bad
                max_vld <= 1'b0;
                if (s2_good) begin
                    PEAK_BIN   <= best_bin_c;
                    PEAK_POWER <= best_pow_c;
                    PEAK_VALID <= 1'b1;
                    FRAME_CNT  <= FRAME_CNT + 16'd1;
                end else begin
                    FRAME_ERR  <= 1'b1;
                end
            end else if (take_c) begin
                max_vld <= 1'b1;
                max_pow <= s2_pow;
                max_bin <= s2_idx;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_search.sv
// Bench for fft_peak_search: two instances (half-spectrum and full-spectrum
// search) share one stimulus stream; expected results are queued per
// instance when a frame-end sample is driven and checked when a pulse appears.
module tb_fft_peak_search;

    localparam int unsigned BN = 8;
    localparam int unsigned FL = 16;

    logic                 clk_300m = 1'b0;
    logic                 locrstn  = 1'b0;
    logic signed [BN-1:0] i_data   = '0;
    logic signed [BN-1:0] q_data   = '0;
    logic                 data_vld = 1'b0;
    logic                 data_last = 1'b0;

    logic [3:0]  pk_bin [2];
    logic [15:0] pk_pow [2];
    logic        pk_vld [2];
    logic        fr_err [2];
    logic [15:0] fr_cnt [2];

    always #5 clk_300m = ~clk_300m;

    int cyc = 0;
    always @(posedge clk_300m) cyc <= cyc + 1;

    fft_peak_search #(.BIT_NUM(BN), .FFT_LEN(FL), .SKIP_DC(1'b1), .SEARCH_HALF(1'b1)) u_dut_h (
        .SYS_CLK(clk_300m), .SYS_RSTN(locrstn),
        .I_DATA_IN(i_data), .Q_DATA_IN(q_data),
        .DATA_IN_VALID(data_vld), .DATA_IN_LAST(data_last),
        .PEAK_BIN(pk_bin[0]), .PEAK_POWER(pk_pow[0]), .PEAK_VALID(pk_vld[0]),
        .FRAME_ERR(fr_err[0]), .FRAME_CNT(fr_cnt[0])
    );

    fft_peak_search #(.BIT_NUM(BN), .FFT_LEN(FL), .SKIP_DC(1'b1), .SEARCH_HALF(1'b0)) u_dut_f (
        .SYS_CLK(clk_300m), .SYS_RSTN(locrstn),
        .I_DATA_IN(i_data), .Q_DATA_IN(q_data),
        .DATA_IN_VALID(data_vld), .DATA_IN_LAST(data_last),
        .PEAK_BIN(pk_bin[1]), .PEAK_POWER(pk_pow[1]), .PEAK_VALID(pk_vld[1]),
        .FRAME_ERR(fr_err[1]), .FRAME_CNT(fr_cnt[1])
    );

    typedef struct {
        logic        err;
        logic [3:0]  bin;
        logic [15:0] pow;
        int          cyc;
    } exp_t;

    // Frame record: up to three overridden bins over an I=Q=1 background
    typedef struct {
        string name;
        int    n;
        bit    last;
        bit    gaps;
        int    b0, i0, q0;
        int    b1, i1, q1;
        int    b2, i2, q2;
        bit    err;
        int    bin_h, pow_h;
        int    bin_f, pow_f;
    } vec_t;

    exp_t        sbq [2][$];
    logic [15:0] exp_cnt  [2];
    logic [3:0]  held_bin [2];
    logic [15:0] held_pow [2];
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        vt [8];

    task automatic chk(input string nm, input int d, input longint act, input longint exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s dut%0d @cyc %0d: got %0d, expected %0d", nm, d, cyc, act, exp_v);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_bin"},   d, pk_bin[d], 0);
            chk({tag, "_pow"},   d, pk_pow[d], 0);
            chk({tag, "_pv"},    d, pk_vld[d], 0);
            chk({tag, "_ferr"},  d, fr_err[d], 0);
            chk({tag, "_cnt"},   d, fr_cnt[d], 0);
        end
    endtask

    task automatic drive_sample(input logic signed [BN-1:0] iv, input logic signed [BN-1:0] qv,
                                input logic lv);
        @(posedge clk_300m); #1;
        data_vld  = 1'b1;
        i_data    = iv;
        q_data    = qv;
        data_last = lv;
    endtask

    task automatic drive_idle();
        @(posedge clk_300m); #1;
        data_vld  = 1'b0;
        data_last = 1'b0;
        i_data    = '0;
        q_data    = '0;
    endtask

    // Drive one frame; frames are not separated by idle cycles
    task automatic run_vec(input vec_t v);
        exp_t e;
        for (int k = 0; k < v.n; k++) begin
            int iv = 1;
            int qv = 1;
            if (k == v.b0) begin iv = v.i0; qv = v.q0; end
            if (k == v.b1) begin iv = v.i1; qv = v.q1; end
            if (k == v.b2) begin iv = v.i2; qv = v.q2; end
            if (v.gaps && k > 0 && $urandom_range(0, 2) == 0)
                repeat ($urandom_range(1, 2)) drive_idle();
            drive_sample(BN'(iv), BN'(qv), v.last && (k == v.n - 1));
            if (k == v.n - 1) begin
                e.err = v.err;
                e.cyc = cyc + 4;
                e.bin = 4'(v.bin_h);
                e.pow = 16'(v.pow_h);
                sbq[0].push_back(e);
                e.bin = 4'(v.bin_f);
                e.pow = 16'(v.pow_f);
                sbq[1].push_back(e);
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 40 && (sbq[0].size() != 0 || sbq[1].size() != 0); k++)
            @(negedge clk_300m);
        chk({tag, "_drain"}, 0, sbq[0].size() + sbq[1].size(), 0);
    endtask

    // Scoreboard: every pulse must match the oldest queued expectation
    always @(negedge clk_300m) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (pk_vld[d] || fr_err[d]) begin
                if (sbq[d].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pulse dut%0d @cyc %0d: got pv=%0d ferr=%0d, expected none",
                             d, cyc, pk_vld[d], fr_err[d]);
                end else begin
                    e = sbq[d].pop_front();
                    chk("pv_ferr_excl", d, pk_vld[d] & fr_err[d], 0);
                    chk("result_kind",  d, fr_err[d], e.err);
                    chk("latency",      d, cyc, e.cyc);
                    if (!e.err) begin
                        exp_cnt[d]  = exp_cnt[d] + 16'd1;
                        held_bin[d] = e.bin;
                        held_pow[d] = e.pow;
                    end
                    chk("peak_bin",   d, pk_bin[d], held_bin[d]);
                    chk("peak_power", d, pk_pow[d], held_pow[d]);
                    chk("frame_cnt",  d, fr_cnt[d], exp_cnt[d]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        for (int d = 0; d < 2; d++) begin
            exp_cnt[d]  = '0;
            held_bin[d] = '0;
            held_pow[d] = '0;
        end
        //         name        n  last gaps  b0  i0   q0    b1  i1  q1   b2  i2   q2  err bh pow_h  bf pow_f
        vt[0] = '{"tone",      16, 1, 0,     0, 127,   0,    5, 100,  0,  -1,   0,   0, 0,  5, 10000, 5, 10000};
        vt[1] = '{"tie_range", 16, 1, 0,     3,  50,  50,    6,  50, 50,  12, 127, 127, 0,  3,  5000, 12, 32258};
        vt[2] = '{"extreme",   16, 1, 0,     7,-128,-128,   -1,   0,  0,  -1,   0,   0, 0,  7, 32768, 7, 32768};
        vt[3] = '{"early_last",10, 1, 0,    -1,   0,   0,   -1,   0,  0,  -1,   0,   0, 1,  0,     0, 0,     0};
        vt[4] = '{"no_last",   16, 0, 0,    -1,   0,   0,   -1,   0,  0,  -1,   0,   0, 1,  0,     0, 0,     0};
        vt[5] = '{"good_after",16, 1, 0,     9,  30,  40,    2,  -3,  4,  -1,   0,   0, 0,  2,    25, 9,  2500};
        vt[6] = '{"btb_a",     16, 1, 1,     2,  90,   0,   -1,   0,  0,  -1,   0,   0, 0,  2,  8100, 2,  8100};
        vt[7] = '{"btb_b",     16, 1, 1,     7,   0, -90,   -1,   0,  0,  -1,   0,   0, 0,  7,  8100, 7,  8100};

        // Reset state
        repeat (2) @(negedge clk_300m);
        check_zero("reset");
        @(posedge clk_300m); #1;
        locrstn = 1'b1;
        drive_idle();

        // All table frames back to back
        for (int v = 0; v < 8; v++) run_vec(vt[v]);
        drive_idle();
        wait_drain("table");

        // Reset mid-frame: bins 0..8 in flight, then reset for 3 cycles
        for (int k = 0; k <= 8; k++) drive_sample(8'sd1, 8'sd1, 1'b0);
        @(posedge clk_300m); #1;
        locrstn   = 1'b0;
        data_vld  = 1'b0;
        data_last = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_cnt[d]  = '0;
            held_bin[d] = '0;
            held_pow[d] = '0;
        end
        repeat (3) begin
            @(negedge clk_300m);
            check_zero("in_reset");
        end
        @(posedge clk_300m); #1;
        locrstn = 1'b1;
        drive_idle();
        rv = '{"post_reset", 16, 1, 0, 4, 60, -70, -1, 0, 0, -1, 0, 0, 0, 4, 8500, 4, 8500};
        run_vec(rv);
        drive_idle();
        wait_drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
